// File: rtl/time_of_day_pkg.sv
// Shared digit limits, widths and the BCD time record for the time-of-day counter.
// Includes the BCD increment helpers used by the carry chain and set logic.
package time_of_day_pkg;

  localparam int unsigned HR_TENS_W = 2;
  localparam int unsigned TENS_W    = 3;
  localparam int unsigned ONES_W    = 4;

  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned ONES_MAX     = 9;
  localparam int unsigned HR_WRAP_TENS = 2;
  localparam int unsigned HR_WRAP_ONES = 3;

  typedef struct packed {
    logic [HR_TENS_W-1:0] hr_tens;
    logic [ONES_W-1:0]    hr_ones;
    logic [TENS_W-1:0]    min_tens;
    logic [ONES_W-1:0]    min_ones;
    logic [TENS_W-1:0]    sec_tens;
    logic [ONES_W-1:0]    sec_ones;
  } bcd_time_t;

  // Modulo-60 BCD increment on {tens, ones}; 59 wraps to 00.
  function automatic logic [TENS_W+ONES_W-1:0] bcd60_inc(input logic [TENS_W+ONES_W-1:0] v);
    logic [TENS_W-1:0] t;
    logic [ONES_W-1:0] o;
    t = v[TENS_W+ONES_W-1:ONES_W];
    o = v[ONES_W-1:0];
    if (o == ONES_W'(ONES_MAX)) begin
      o = '0;
      t = (t == TENS_W'(SEC_TENS_MAX)) ? '0 : t + TENS_W'(1);
    end else begin
      o = o + ONES_W'(1);
    end
    return {t, o};
  endfunction

  function automatic logic bcd60_is_max(input logic [TENS_W+ONES_W-1:0] v);
    return v == {TENS_W'(MIN_TENS_MAX), ONES_W'(ONES_MAX)};
  endfunction

  // Modulo-24 BCD increment on {tens, ones}; 23 wraps to 00.
  function automatic logic [HR_TENS_W+ONES_W-1:0] bcd24_inc(input logic [HR_TENS_W+ONES_W-1:0] v);
    logic [HR_TENS_W-1:0] t;
    logic [ONES_W-1:0]    o;
    t = v[HR_TENS_W+ONES_W-1:ONES_W];
    o = v[ONES_W-1:0];
    if (t == HR_TENS_W'(HR_WRAP_TENS) && o == ONES_W'(HR_WRAP_ONES)) begin
      t = '0;
      o = '0;
    end else if (o == ONES_W'(ONES_MAX)) begin
      t = t + HR_TENS_W'(1);
      o = '0;
    end else begin
      o = o + ONES_W'(1);
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// rise is high for one cycle when the synchronised level goes 0 -> 1.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD clock driven by the synchronised 4 Hz slow clock, with a set mode
// (minute/hour buttons) and a half-second blink flag for the display.
module time_of_day_counter
  import time_of_day_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 slow_clk_in,
  input  logic                 set_mode,
  input  logic                 inc_min,
  input  logic                 inc_hr,
  output logic [HR_TENS_W-1:0] hr_tens,
  output logic [ONES_W-1:0]    hr_ones,
  output logic [TENS_W-1:0]    min_tens,
  output logic [ONES_W-1:0]    min_ones,
  output logic [TENS_W-1:0]    sec_tens,
  output logic [ONES_W-1:0]    sec_ones,
  output logic                 sec_pulse,
  output logic                 blink
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);

  logic w_slow_level, w_slow_rise;
  logic w_set_level,  w_set_rise;
  logic w_min_level,  w_min_rise;
  logic w_hr_level,   w_hr_rise;
  logic [2:0] w_unused_levels;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_slow (
    .clk_in(clk_in), .reset(reset), .d(slow_clk_in), .level(w_slow_level), .rise(w_slow_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set (
    .clk_in(clk_in), .reset(reset), .d(set_mode), .level(w_set_level), .rise(w_set_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min (
    .clk_in(clk_in), .reset(reset), .d(inc_min), .level(w_min_level), .rise(w_min_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hr (
    .clk_in(clk_in), .reset(reset), .d(inc_hr), .level(w_hr_level), .rise(w_hr_rise));

  assign w_unused_levels = {w_slow_level, w_min_level, w_hr_level};

  logic [PW-1:0] r_presc;
  logic          r_set_prev;
  logic          r_sec_pulse;
  logic          r_blink;
  bcd_time_t     r_time;

  logic          w_set_fall;
  logic          w_set_edge;
  logic          w_wrap;
  logic [PW-1:0] w_presc_next;
  bcd_time_t     w_time_next;

  assign w_set_fall = ~w_set_level & r_set_prev;
  assign w_set_edge = w_set_rise | w_set_fall;
  // A set-mode transition restarts the second, so it suppresses any wrap that cycle.
  assign w_wrap     = w_slow_rise && (r_presc == PRESC_MAX) && !w_set_edge;

  always_comb begin
    w_presc_next = r_presc;
    if (w_set_edge) begin
      w_presc_next = '0;
    end else if (w_slow_rise) begin
      w_presc_next = w_wrap ? '0 : r_presc + PW'(1);
    end
  end

  // Carry chain in run mode; independent minute/hour increments in set mode.
  always_comb begin
    w_time_next = r_time;
    if (w_set_rise) begin
      w_time_next.sec_tens = '0;
      w_time_next.sec_ones = '0;
    end else if (!w_set_level && w_wrap) begin
      {w_time_next.sec_tens, w_time_next.sec_ones} = bcd60_inc({r_time.sec_tens, r_time.sec_ones});
      if (bcd60_is_max({r_time.sec_tens, r_time.sec_ones})) begin
        {w_time_next.min_tens, w_time_next.min_ones} = bcd60_inc({r_time.min_tens, r_time.min_ones});
        if (bcd60_is_max({r_time.min_tens, r_time.min_ones})) begin
          {w_time_next.hr_tens, w_time_next.hr_ones} = bcd24_inc({r_time.hr_tens, r_time.hr_ones});
        end
      end
    end
    if (w_set_level && w_min_rise) begin
      {w_time_next.min_tens, w_time_next.min_ones} = bcd60_inc({r_time.min_tens, r_time.min_ones});
    end
    if (w_set_level && w_hr_rise) begin
      {w_time_next.hr_tens, w_time_next.hr_ones} = bcd24_inc({r_time.hr_tens, r_time.hr_ones});
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_presc     <= '0;
      r_set_prev  <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_blink     <= 1'b0;
      r_time      <= '0;
    end else begin
      r_presc     <= w_presc_next;
      r_set_prev  <= w_set_level;
      r_sec_pulse <= w_wrap;
      r_blink     <= (w_presc_next < PRESC_HALF);
      r_time      <= w_time_next;
    end
  end

  assign hr_tens   = r_time.hr_tens;
  assign hr_ones   = r_time.hr_ones;
  assign min_tens  = r_time.min_tens;
  assign min_ones  = r_time.min_ones;
  assign sec_tens  = r_time.sec_tens;
  assign sec_ones  = r_time.sec_ones;
  assign sec_pulse = r_sec_pulse;
  assign blink     = r_blink;

endmodule
